// File: rtl/oam_dma_controller.sv
// oam_dma_controller
// Sprite-OAM DMA sequencer ($4014 semantics). On an accepted start strobe it
// halts the CPU-side bus master and copies NUM_BYTES bytes from memory page
// {page, 8'h00..} into the PPU OAMDATA register, one READ/WRITE pair per byte,
// with every READ aligned to an even (cyc_odd = 0) CPU cycle.
//
// Request semantics: dma_start is a one-cycle strobe with no ready/ack.
// It is accepted only when the sequencer is IDLE, in which case dma_page is
// latched in the same cycle. A strobe seen in any other state, including the
// DONE cycle, is dropped and leaves the latched page untouched. Completion is
// signalled by the one-cycle dma_done pulse.
//
// Memory interface: mem_rd is a read strobe and mem_rdata returns one cycle
// later (synchronous, latency 1). Data is therefore valid during WRITE and is
// passed straight through to ppu_wdata in that state only.

module oam_dma_controller #(
    parameter int          NUM_BYTES    = 256,
    parameter logic [2:0]  OAMDATA_ADDR = 3'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic        cpu_halt,
    output logic        dma_busy,
    output logic        dma_done,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  ppu_address,
    output logic [7:0]  ppu_wdata,
    output logic        ppu_rw,
    output logic        ppu_cs,
    output logic [2:0]  dbg_state
);

    // FSM encoding; IDLE must stay 0 so the reset state reads as all-zero.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_ALIGN = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Index of the final byte; the WRITE of this byte ends the transfer.
    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [7:0]  idx_q;
    logic [7:0]  page_q;
    logic        cyc_odd_q;
    logic [15:0] addr_hold_q;
    logic        start_accept;

    // A strobe only counts when the sequencer is idle.
    assign start_accept = (state_q == ST_IDLE) && dma_start;

    // Expose the FSM state for checkers and waveform debug.
    assign dbg_state = state_q;

    // CPU get/put parity: free-running toggle from reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_odd_q <= 1'b0;
        end else begin
            cyc_odd_q <= ~cyc_odd_q;
        end
    end

    // Next-state logic for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dma_start) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // The cycle after HALT has parity ~cyc_odd_q; READ must land
                // on an even cycle, otherwise burn one ALIGN cycle first.
                if (cyc_odd_q) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Page latch and byte index: loaded on accept, index advances per write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page_q <= 8'h00;
            idx_q  <= 8'h00;
        end else if (start_accept) begin
            page_q <= dma_page;
            idx_q  <= 8'h00;
        end else if (state_q == ST_WRITE) begin
            // 8-bit wrap; the index never carries into the page.
            idx_q <= idx_q + 8'h01;
        end
    end

    // Remember the last read address so mem_addr is stable outside READ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_hold_q <= 16'h0000;
        end else if (state_q == ST_READ) begin
            addr_hold_q <= {page_q, idx_q};
        end
    end

    // Output decode: every output is a function of the current state only,
    // so nothing moves in the strobe cycle and reset clears them at once.
    always_comb begin
        cpu_halt    = 1'b0;
        dma_busy    = 1'b0;
        dma_done    = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = addr_hold_q;
        ppu_address = 3'd0;
        ppu_wdata   = 8'h00;
        ppu_rw      = 1'b1;
        ppu_cs      = 1'b0;
        case (state_q)
            ST_HALT, ST_ALIGN: begin
                cpu_halt = 1'b1;
                dma_busy = 1'b1;
            end
            ST_READ: begin
                cpu_halt = 1'b1;
                dma_busy = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {page_q, idx_q};
            end
            ST_WRITE: begin
                cpu_halt    = 1'b1;
                dma_busy    = 1'b1;
                ppu_cs      = 1'b1;
                ppu_rw      = 1'b0;
                ppu_address = OAMDATA_ADDR;
                ppu_wdata   = mem_rdata;
            end
            ST_DONE: begin
                dma_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb_oam_dma_controller
// Self-checking bench for the OAM DMA sequencer: a table of directed
// transfers, hand-written corner sequences (strobe in DONE and right after,
// async reset mid-transfer) and randomized transfers, all checked against a
// transfer-level reference model (expected address/data queues, cycle counts).

module tb_oam_dma_controller;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        dma_start;
    logic [7:0]  dma_page;
    logic        cpu_halt;
    logic        dma_busy;
    logic        dma_done;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic [2:0]  ppu_address;
    logic [7:0]  ppu_wdata;
    logic        ppu_rw;
    logic        ppu_cs;
    logic [2:0]  dbg_state;

    initial forever #5 clk = ~clk;

    oam_dma_controller #(
        .NUM_BYTES    (256),
        .OAMDATA_ADDR (3'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dma_start   (dma_start),
        .dma_page    (dma_page),
        .cpu_halt    (cpu_halt),
        .dma_busy    (dma_busy),
        .dma_done    (dma_done),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .ppu_address (ppu_address),
        .ppu_wdata   (ppu_wdata),
        .ppu_rw      (ppu_rw),
        .ppu_cs      (ppu_cs),
        .dbg_state   (dbg_state)
    );

    // Cycle counter and reference CPU parity (toggles every clk from reset).
    int   cyc_n = 0;
    logic tb_par;
    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(posedge clk or posedge reset) begin
        if (reset) tb_par <= 1'b0;
        else       tb_par <= ~tb_par;
    end

    // ---------------- memory model ----------------
    logic [7:0] rand_mem [0:65535];
    logic       mem_xor;

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        if (mem_xor) return a[7:0] ^ 8'h5A;
        return rand_mem[a];
    endfunction

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_val(mem_addr);
    end

    // ---------------- monitor (samples on negedge) ----------------
    int          halt_cnt  = 0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          last_halt = 0;
    int          viol      = 0;
    logic [15:0] got_addr[$];
    logic [7:0]  got_data[$];
    int          rd_cyc_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (cpu_halt) begin
                halt_cnt  = halt_cnt + 1;
                last_halt = cyc_n;
            end
            if (dma_busy != cpu_halt) viol = viol + 1;
            if (mem_rd) begin
                got_addr.push_back(mem_addr);
                rd_cyc_q.push_back(cyc_n);
                if (tb_par != 1'b0) viol = viol + 1;
                if (ppu_cs) viol = viol + 1;
            end
            if (ppu_cs) begin
                got_data.push_back(ppu_wdata);
                if (ppu_address != 3'd4 || ppu_rw != 1'b0) viol = viol + 1;
            end else begin
                if (ppu_wdata != 8'h00 || ppu_rw != 1'b1 || ppu_address != 3'd0) viol = viol + 1;
            end
            if (dma_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc_n;
                if (cpu_halt) viol = viol + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total = n_total + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    int halt_base, done_base, addr_base, data_base, viol_base;

    task automatic snapshot();
        halt_base = halt_cnt;
        done_base = done_cnt;
        addr_base = got_addr.size();
        data_base = got_data.size();
        viol_base = viol;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_halt"},    cpu_halt,    0);
        check({tag, "_dma_busy"},    dma_busy,    0);
        check({tag, "_dma_done"},    dma_done,    0);
        check({tag, "_mem_rd"},      mem_rd,      0);
        check({tag, "_mem_addr"},    mem_addr,    0);
        check({tag, "_ppu_cs"},      ppu_cs,      0);
        check({tag, "_ppu_rw"},      ppu_rw,      1);
        check({tag, "_ppu_address"}, ppu_address, 0);
        check({tag, "_ppu_wdata"},   ppu_wdata,   0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_xfer(input logic [7:0] page, input logic want_par, output int sc);
        @(posedge clk); #1;
        while (tb_par != want_par) begin
            @(posedge clk); #1;
        end
        dma_start = 1'b1;
        dma_page  = page;
        sc        = cyc_n;
        @(posedge clk); #1;
        dma_start = 1'b0;
        dma_page  = 8'($urandom);
    endtask

    task automatic strobe_mid(input int delay, input logic [7:0] page);
        repeat (delay) @(posedge clk);
        #1;
        dma_start = 1'b1;
        dma_page  = page;
        @(posedge clk); #1;
        dma_start = 1'b0;
        dma_page  = 8'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == done_base && n < 700) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_within_budget", (n < 700), 1);
    endtask

    // Transfer-level model: NUM_BYTES reads of {page,k} in order, each write
    // carrying mem(page,k); busy = 1 + align + 512, align = strobe parity.
    task automatic check_xfer(input logic [7:0] page, input int sc, input int exp_busy, input int exp_ofs);
        logic [15:0] exp_addr_q[$];
        logic [7:0]  exp_q[$];
        int nrd, nwr, am, dm;
        for (int k = 0; k < 256; k++) begin
            exp_addr_q.push_back({page, 8'(k)});
            exp_q.push_back(mem_val({page, 8'(k)}));
        end
        nrd = got_addr.size() - addr_base;
        nwr = got_data.size() - data_base;
        check("read_count",  nrd, 256);
        check("write_count", nwr, 256);
        am = 0;
        dm = 0;
        for (int i = 0; i < 256; i++) begin
            if (i < nrd && got_addr[addr_base + i] != exp_addr_q[i]) am++;
            if (i < nwr && got_data[data_base + i] != exp_q[i]) dm++;
        end
        check("addr_seq_mismatches", am, 0);
        check("wdata_seq_mismatches", dm, 0);
        if (nrd > 0) begin
            check("first_read_offset", rd_cyc_q[addr_base] - sc, exp_ofs);
            check("last_read_addr", got_addr[got_addr.size() - 1], {page, 8'hFF});
        end
        check("busy_cycles", halt_cnt - halt_base, exp_busy);
        check("done_pulses", done_cnt - done_base, 1);
        check("done_cycle_offset", done_cyc - sc, exp_busy + 1);
        check("done_at_halt_fall", done_cyc - last_halt, 1);
        check("cycle_invariants", viol - viol_base, 0);
    endtask

    task automatic run_xfer(input logic [7:0] page, input logic par, input logic mid,
                            input logic [7:0] mid_page, input int exp_busy, input int exp_ofs);
        int sc;
        snapshot();
        start_xfer(page, par, sc);
        if (mid) strobe_mid($urandom_range(1, 400), mid_page);
        wait_done();
        check_xfer(page, sc, exp_busy, exp_ofs);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] page;
        logic       par;
        logic       xor_mem;
        logic       mid;
        logic [7:0] mid_page;
        int         exp_busy;
        int         exp_ofs;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int sc, sc2, n;
        logic par2;

        dma_start = 1'b0;
        dma_page  = 8'h00;
        mem_xor   = 1'b1;
        reset     = 1'b1;
        for (int a = 0; a < 65536; a++) rand_mem[a] = 8'($urandom);

        vecs[0] = '{page: 8'h02, par: 1'b0, xor_mem: 1'b1, mid: 1'b0, mid_page: 8'h00, exp_busy: 513, exp_ofs: 2};
        vecs[1] = '{page: 8'h02, par: 1'b1, xor_mem: 1'b1, mid: 1'b0, mid_page: 8'h00, exp_busy: 514, exp_ofs: 3};
        vecs[2] = '{page: 8'hFF, par: 1'b0, xor_mem: 1'b1, mid: 1'b0, mid_page: 8'h00, exp_busy: 513, exp_ofs: 2};
        vecs[3] = '{page: 8'h02, par: 1'b1, xor_mem: 1'b1, mid: 1'b1, mid_page: 8'h07, exp_busy: 514, exp_ofs: 3};
        vecs[4] = '{page: 8'h00, par: 1'b0, xor_mem: 1'b0, mid: 1'b1, mid_page: 8'h07, exp_busy: 513, exp_ofs: 2};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            mem_xor = vecs[v].xor_mem;
            run_xfer(vecs[v].page, vecs[v].par, vecs[v].mid, vecs[v].mid_page,
                     vecs[v].exp_busy, vecs[v].exp_ofs);
        end

        // Strobe in the DONE cycle is ignored; strobe on the next cycle is accepted.
        mem_xor = 1'b1;
        snapshot();
        start_xfer(8'h02, 1'b0, sc);
        n = 0;
        while (cyc_n != sc + 514 && n < 700) begin
            @(posedge clk); #1;
            n++;
        end
        dma_start = 1'b1;
        dma_page  = 8'h07;
        @(posedge clk); #1;
        dma_page  = 8'h03;
        sc2       = cyc_n;
        par2      = tb_par;
        check_xfer(8'h02, sc, 513, 2);
        snapshot();
        @(posedge clk); #1;
        dma_start = 1'b0;
        dma_page  = 8'($urandom);
        wait_done();
        check_xfer(8'h03, sc2, 513 + int'(par2), 2 + int'(par2));

        // Asynchronous reset at write #100, then a fresh full transfer.
        snapshot();
        start_xfer(8'h02, 1'b0, sc);
        n = 0;
        while ((got_data.size() - data_base) < 100 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("async");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("writes_before_reset", got_data.size() - data_base, 100);
        check("no_done_after_reset", done_cnt - done_base, 0);
        run_xfer(8'h02, 1'b0, 1'b0, 8'h00, 513, 2);

        // Randomized transfers against the model.
        for (int r = 0; r < 6; r++) begin
            logic [7:0] pg;
            logic       p;
            pg      = 8'($urandom_range(0, 255));
            p       = 1'($urandom_range(0, 1));
            mem_xor = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            run_xfer(pg, p, 1'($urandom_range(0, 1)), pg ^ 8'h05, 513 + int'(p), 2 + int'(p));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sequences the sprite-OAM DMA transfer ($4014 semantics) into the PPU's CPU-side register port.
- On a start strobe carrying a source page, it halts the CPU-side bus master and copies 256 bytes from memory page {page,8'h00..8'hFF} into PPU register OAMDATA.
- Sits between the CPU-clock-domain bus master (PPU_driver / future 6502), CPU-side memory, and the PPU register port (address, data, rw, cs); runs on clk_CPU.

Parameters:
- NUM_BYTES, 256, bytes transferred per DMA; power of two, 2..256.
- OAMDATA_ADDR, 3'd4, PPU register select driven during write cycles.

Ports:
- clk  in  1  CPU clock (clk_CPU).
- reset  in  1  asynchronous, active-high reset.
- dma_start  in  1  one-cycle request strobe; sampled every clk.
- dma_page  in  8  source page (high address byte); sampled with dma_start.
- cpu_halt  out  1  high while DMA owns the bus; the master must not drive the bus or PPU port.
- dma_busy  out  1  high from the cycle after an accepted start until the done cycle.
- dma_done  out  1  one-cycle pulse after the last write.
- mem_addr  out  16  source read address.
- mem_rd  out  1  read strobe; the memory returns mem_rdata in the next cycle (synchronous, latency 1).
- mem_rdata  in  8  read data.
- ppu_address  out  3  PPU register select.
- ppu_wdata  out  8  write data to the PPU register port.
- ppu_rw  out  1  1 = read/idle, 0 = write.
- ppu_cs  out  1  PPU chip select for DMA cycles.

Behaviour:
- Reset values: all outputs 0 except ppu_rw = 1. State IDLE, byte index 0, page register 0, parity register cyc_odd = 0.
- cyc_odd toggles every clk from reset. It tracks CPU get/put cycles.
- States: IDLE, HALT, ALIGN, READ, WRITE, DONE.
- IDLE:
  - dma_start = 1 latches dma_page and moves to HALT.
  - No output changes in the strobe cycle.
- HALT: one dummy cycle.
  - cpu_halt = 1 and dma_busy = 1 from this cycle onward.
  - Next state is READ if the next cycle has cyc_odd = 0, otherwise ALIGN.
- ALIGN: one dummy cycle, then READ. READ always lands on cyc_odd = 0.
- READ:
  - mem_rd = 1, mem_addr = {page, idx}.
  - ppu_cs = 0, ppu_rw = 1.
  - Next state is WRITE.
- WRITE:
  - ppu_cs = 1, ppu_rw = 0, ppu_address = OAMDATA_ADDR.
  - ppu_wdata = mem_rdata, a combinational pass-through valid only in this state; 0 otherwise.
  - idx increments, 8-bit wrap.
  - If idx was NUM_BYTES-1, next state is DONE, otherwise READ.
- DONE: one cycle.
  - dma_done = 1, cpu_halt = 0, dma_busy = 0.
  - Returns to IDLE, so the next start is accepted in the following cycle.
- Total busy cycles: 1 + align + 2*NUM_BYTES, i.e. 513 or 514 for 256 bytes.
  - Start strobe on a cyc_odd = 0 cycle: 513.
  - Start strobe on a cyc_odd = 1 cycle: 514.
- Outside WRITE: ppu_cs = 0, ppu_rw = 1, ppu_address = 0.
- Outside READ: mem_rd = 0. mem_addr holds its last value (don't-care to consumers).
- dma_start while not IDLE (including the DONE cycle): ignored; the page register is unchanged.
- dma_page is a don't-care without dma_start.
- Page 8'hFF: addresses FF00..FFFF. There is no carry into the page and no wrap into other pages.
- reset asserted mid-transfer: immediate return to reset values. No further PPU writes and no dma_done pulse. The partial OAM contents are left as-is.

Test Plan:
- Reset, then dma_start with page 8'h02 on a cyc_odd = 0 cycle.
  - cpu_halt high for exactly 513 cycles, no ALIGN.
  - 256 READ/WRITE pairs, mem_addr 0200..02FF in order.
  - 256 ppu_cs pulses with ppu_address = 4, ppu_rw = 0.
  - dma_done once, in the cycle cpu_halt falls.
- Same transfer started on a cyc_odd = 1 cycle: one ALIGN cycle, busy 514 cycles; the first mem_rd falls on cyc_odd = 0.
- Memory model returns addr[7:0]^8'h5A.
  - The k-th PPU write carries k^8'h5A for k = 0..255.
  - ppu_wdata is 0 whenever ppu_cs = 0.
- Page 8'hFF: last read address FFFF, then DONE; no access to 0000.
- Second dma_start (page 8'h07) mid-transfer: ignored; all addresses stay in page 02. A start strobe on the cycle after DONE is accepted.
- Assert reset at write #100:
  - All outputs go to reset values asynchronously (ppu_rw = 1).
  - No dma_done pulse.
  - A fresh start afterwards runs a complete 256-byte transfer from idx 0.
